uart_tx_frame: RTL

UART_TX_FRAME -- requirements
Module: uart_tx_frame

---
 rtl/uart_tx_frame.sv | 106 ++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first payload, optional parity, stop.
// One serial bit per CLK cycle; TX_OUT and busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nx;
  logic [DATA_WIDTH-1:0]   data;
  logic                    par_en;
  logic                    par_typ;

  assign cnt_nx = cnt + CW'(1);

  // Outputs are registered, so each branch loads the bit of the state
  // being entered rather than the one being left.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      data    <= '0;
      par_en  <= 1'b0;
      par_typ <= 1'b0;
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            data    <= P_DATA;
            par_en  <= PAR_EN;
            par_typ <= PAR_TYP;
            state   <= START;
            TX_OUT  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          TX_OUT <= data[0];
        end
        DATA: begin
          if (cnt == LAST) begin
            if (par_en) begin
              state  <= PARITY;
              TX_OUT <= (^data) ^ par_typ;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            cnt    <= cnt_nx;
            TX_OUT <= data[cnt_nx];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: begin
          if (Data_Valid) begin
            data    <= P_DATA;
            par_en  <= PAR_EN;
            par_typ <= PAR_TYP;
            state   <= START;
            TX_OUT  <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
